// File: rtl/pl_skid_latch_pkg.sv
// Shared types for the pipeline skid latch.
// cpu_types_pkg supplies the machine word; pl_pkg builds latch types on it.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

package pl_pkg;
    import cpu_types_pkg::word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pl_state_t;

    typedef struct packed {
        word_t instruction;
        word_t next_address;
    } ifid_payload_t;

    localparam int IFID_W = $bits(ifid_payload_t);
endpackage

// File: rtl/pl_skid_latch_if.sv
// Handshake bundle between two pipeline stages through the skid latch.
// slave: latch side; master: the surrounding stages / driver side.
interface pl_skid_latch_if #(
    parameter int DATA_W = 64
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pl_skid_latch_sat_counter.sv
// Saturating up-counter: adds 'amount' when 'inc' is high, sticks at all-ones.
// Needs CNT_W >= 2 so the one-bit-wider sum cannot wrap.
module pl_sat_counter #(
    parameter int CNT_W = 16,
    parameter int AMT_W = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic [AMT_W-1:0] amount,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_sum;

    assign w_sum = {1'b0, r_cnt} + {{(CNT_W + 1 - AMT_W){1'b0}}, amount};
    assign count = r_cnt;

    // Accumulate, clamping to the maximum on overflow.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_cnt <= '0;
        else if (inc)
            r_cnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
endmodule

// File: rtl/pl_skid_latch.sv
// Pipeline latch with valid/ready handshake, 2-entry skid buffer and flush.
// in_ready and out_valid come straight from flops, so neither side sees a
// combinational path through the latch. Optional perf counters are built
// when PL_SKID_PERF_EN is defined.
module pl_skid_latch
    import pl_pkg::*;
#(
    parameter int DATA_W = IFID_W
`ifdef PL_SKID_PERF_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             CLK,
    input  logic             nRST,
    pl_skid_latch_if.slave   bus
`ifdef PL_SKID_PERF_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);
    pl_state_t         r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_out_valid;
    logic              r_in_ready;
    logic [1:0]        r_occ;

    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;
    assign bus.occupancy = r_occ;

    // EMPTY/BUSY/FULL controller; flush beats every transition, data regs hold on flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd0;
        end else if (bus.flush) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd0;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) begin
                    r_main      <= bus.in_data;
                    r_state     <= BUSY;
                    r_out_valid <= 1'b1;
                    r_occ       <= 2'd1;
                end
                BUSY: case ({w_in_fire, w_out_fire})
                    2'b11: r_main <= bus.in_data;
                    2'b10: begin
                        r_skid     <= bus.in_data;
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                        r_occ      <= 2'd2;
                    end
                    2'b01: begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                        r_occ       <= 2'd0;
                    end
                    default: ;
                endcase
                FULL: if (w_out_fire) begin
                    r_main     <= r_skid;
                    r_state    <= BUSY;
                    r_in_ready <= 1'b1;
                    r_occ      <= 2'd1;
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_occ       <= 2'd0;
                end
            endcase
        end
    end

`ifdef PL_SKID_PERF_EN
    logic       w_stall;
    logic [1:0] w_killed;
    logic [1:0] w_flush_amt;

    assign w_stall = r_out_valid & ~bus.out_ready & ~bus.flush;

    // Entries still held after any same-cycle delivery are the ones a flush kills.
    always_comb begin
        w_killed = 2'd0;
        case (r_state)
            BUSY:    w_killed = w_out_fire ? 2'd0 : 2'd1;
            FULL:    w_killed = w_out_fire ? 2'd1 : 2'd2;
            default: w_killed = 2'd0;
        endcase
    end

    assign w_flush_amt = w_killed + {1'b0, w_in_fire};

    pl_sat_counter #(.CNT_W(CNT_W), .AMT_W(2)) u_stall_cnt (
        .CLK    (CLK),
        .nRST   (nRST),
        .inc    (w_stall),
        .amount (2'd1),
        .count  (stall_cnt)
    );

    pl_sat_counter #(.CNT_W(CNT_W), .AMT_W(2)) u_flush_cnt (
        .CLK    (CLK),
        .nRST   (nRST),
        .inc    (bus.flush),
        .amount (w_flush_amt),
        .count  (flush_cnt)
    );
`endif
endmodule
